// File: rtl/flow_pkg.sv
// Shared constants and types for the flow_controller instruction sequencer.
package flow_pkg;

    localparam int WORD_W  = 16;
    localparam int FIELD_W = 4;

    // Opcodes held in instruction bits [15:12]; unlisted values execute as NOP.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALUR = 4'h1;
    localparam logic [3:0] OP_ALUI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_PUSH = 4'h5;
    localparam logic [3:0] OP_POP  = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Branch condition codes carried in the f field of a BR word.
    localparam logic [3:0] COND_ALWAYS   = 4'h0;
    localparam logic [3:0] COND_ZERO     = 4'h1;
    localparam logic [3:0] COND_NZERO    = 4'h2;
    localparam logic [3:0] COND_SIGN     = 4'h3;
    localparam logic [3:0] COND_NSIGN    = 4'h4;

    // Datapath ALU pass-through functions used for address and jump moves.
    localparam logic [3:0] ALU_PASS_A = 4'hE;
    localparam logic [3:0] ALU_PASS_B = 4'hF;

    // Write-back source selection for the destination register.
    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_MEM  = 2'b10;
    localparam logic [1:0] LOAD_STK  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_IMMLATCH,
        ST_EXEC,
        ST_CHECK,
        ST_HALT
    } flow_state_t;

    // Opcodes whose second word is an immediate operand.
    function automatic logic needs_imm(input logic [3:0] op);
        return (op == OP_ALUI) || (op == OP_BR);
    endfunction

    // Opcodes whose result must be checked against the ALU error bit.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ALUR) || (op == OP_ALUI);
    endfunction

endpackage

// File: rtl/branch_condition.sv
// Combinational evaluation of a BR condition against the register flag vectors.
module branch_condition
    import flow_pkg::*;
(
    input  logic [3:0]  f,
    input  logic [3:0]  rs,
    input  logic [15:0] zeroflag,
    input  logic [15:0] signflag,
    output logic        taken
);

    // Select the flag of register rs named by the condition code.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        taken = 1'b0;
        case (f)
            COND_ALWAYS: taken = 1'b1;
            COND_ZERO:   taken = zeroflag[rs];
            COND_NZERO:  taken = !zeroflag[rs];
            COND_SIGN:   taken = signflag[rs];
            COND_NSIGN:  taken = !signflag[rs];
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flow_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer driving the datapath control inputs.
module flow_controller
    import flow_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [15:0] zeroflag,
    input  logic [15:0] signflag,
    input  logic [15:0] errorbit,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic [3:0]  alu_out_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic        halted,
    output logic        fault
);

    flow_state_t state;
    logic [15:0] ir;
    logic [15:0] imm;
    logic        br_taken;
    logic        enter_exec;

    logic [3:0] ir_op;
    logic [3:0] ir_rd;
    logic [3:0] ir_rs;
    logic [3:0] ir_f;

    assign ir_op = ir[15:12];
    assign ir_rd = ir[11:8];
    assign ir_rs = ir[7:4];
    assign ir_f  = ir[3:0];

    branch_condition u_branch_condition (
        .f        (ir_f),
        .rs       (ir_rs),
        .zeroflag (zeroflag),
        .signflag (signflag),
        .taken    (br_taken)
    );

    // Flag the clock edge on which the sequencer moves into EXEC.
    always_comb begin
        enter_exec = 1'b0;
        if (state == ST_IMMLATCH)
            enter_exec = 1'b1;
        else if (state == ST_DECODE && !needs_imm(ir_op) && ir_op != OP_HALT)
            enter_exec = 1'b1;
    end

    // Advance the instruction sequence and register every control output for the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                     <= ST_FETCH;
            ir                        <= '0;
            imm                       <= '0;
            program_counter_increment <= 1'b0;
            alu_op                    <= '0;
            alu_a_select              <= '0;
            alu_b_select              <= '0;
            alu_out_select            <= '0;
            alu_a_source              <= 1'b0;
            alu_b_source              <= 1'b0;
            alu_a_altern              <= '0;
            alu_b_altern              <= '0;
            alu_load_src              <= LOAD_NONE;
            alu_store_to_mem          <= 1'b0;
            alu_store_to_stk          <= 1'b0;
            halted                    <= 1'b0;
            fault                     <= 1'b0;
        end else begin
            // NOTE: controls fall back to idle every cycle, so a strobe lasts only the cycle that raises it.
            program_counter_increment <= 1'b0;
            alu_op                    <= '0;
            alu_a_select              <= '0;
            alu_b_select              <= '0;
            alu_out_select            <= '0;
            alu_a_source              <= 1'b0;
            alu_b_source              <= 1'b0;
            alu_a_altern              <= '0;
            alu_b_altern              <= '0;
            alu_load_src              <= LOAD_NONE;
            alu_store_to_mem          <= 1'b0;
            alu_store_to_stk          <= 1'b0;

            case (state)
                ST_FETCH: begin
                    // The word at PC has settled; capture it and consume it during DECODE.
                    ir                        <= instruction;
                    program_counter_increment <= 1'b1;
                    state                     <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (needs_imm(ir_op)) begin
                        state <= ST_IMM;
                    end else if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_IMM: begin
                    // Immediate word has settled; capture it and consume it during IMMLATCH.
                    imm                       <= instruction;
                    program_counter_increment <= 1'b1;
                    state                     <= ST_IMMLATCH;
                end
                ST_IMMLATCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= is_alu_op(ir_op) ? ST_CHECK : ST_FETCH;
                end
                ST_CHECK: begin
                    if (errorbit[ir_rd]) begin
                        halted <= 1'b1;
                        fault  <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase

            // EXEC controls are loaded on the edge entering EXEC so they are stable for the datapath negedge.
            if (enter_exec) begin
                case (ir_op)
                    OP_ALUR: begin
                        alu_op         <= ir_f;
                        alu_a_select   <= ir_rd;
                        alu_b_select   <= ir_rs;
                        alu_out_select <= ir_rd;
                        alu_load_src   <= LOAD_ALU;
                    end
                    OP_ALUI: begin
                        alu_op         <= ir_f;
                        alu_a_select   <= ir_rd;
                        alu_b_source   <= 1'b1;
                        alu_b_altern   <= imm;
                        alu_out_select <= ir_rd;
                        alu_load_src   <= LOAD_ALU;
                    end
                    OP_LD, OP_POP: begin
                        alu_op         <= ALU_PASS_A;
                        alu_a_select   <= ir_rs;
                        alu_out_select <= ir_rd;
                        alu_load_src   <= (ir_op == OP_LD) ? LOAD_MEM : LOAD_STK;
                    end
                    OP_ST, OP_PUSH: begin
                        alu_op           <= ALU_PASS_A;
                        alu_a_select     <= ir_rs;
                        alu_out_select   <= ir_rd;
                        alu_store_to_mem <= (ir_op == OP_ST);
                        alu_store_to_stk <= (ir_op == OP_PUSH);
                    end
                    OP_BR: begin
                        // A taken branch writes the absolute target into register 0 (the PC).
                        if (br_taken) begin
                            alu_op         <= ALU_PASS_B;
                            alu_b_source   <= 1'b1;
                            alu_b_altern   <= imm;
                            alu_out_select <= 4'd0;
                            alu_load_src   <= LOAD_ALU;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flow_controller.sv
// Self-checking bench for flow_controller: tiny PC/program model plus instruction-level reference.
`timescale 1ns/1ps
module tb_flow_controller;
    import flow_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction;
    logic [15:0] zeroflag = '0;
    logic [15:0] signflag = '0;
    logic [15:0] errorbit = '0;
    logic        program_counter_increment;
    logic [3:0]  alu_op, alu_a_select, alu_b_select, alu_out_select;
    logic        alu_a_source, alu_b_source;
    logic [15:0] alu_a_altern, alu_b_altern;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem, alu_store_to_stk;
    logic        halted, fault;

    flow_controller dut (
        .clock                     (clock),
        .reset                     (reset),
        .instruction               (instruction),
        .zeroflag                  (zeroflag),
        .signflag                  (signflag),
        .errorbit                  (errorbit),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_out_select            (alu_out_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_load_src              (alu_load_src),
        .alu_store_to_mem          (alu_store_to_mem),
        .alu_store_to_stk          (alu_store_to_stk),
        .halted                    (halted),
        .fault                     (fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic [3:0]  out_sel;
        logic        a_src;
        logic        b_src;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [1:0]  load;
        logic        st_mem;
        logic        st_stk;
    } ev_t;

    logic [15:0] prog [0:255];
    logic [15:0] pc = '0;
    logic [15:0] pc_start = '0;
    int          cyc = 0;
    int          overlap = 0;
    ev_t         mon_e;
    ev_t         act_ev[$];
    ev_t         exp_ev[$];
    logic [31:0] act_pulse[$];
    logic [31:0] exp_pulse[$];
    logic [15:0] exp_pc;
    logic        exp_fault;
    int          checks = 0;
    int          passes = 0;

    assign instruction = prog[pc[7:0]];

    // Datapath stand-in: commits on negedge, records every strobe cycle and PC pulse.
    always @(negedge clock) begin
        if (reset) begin
            pc = pc_start;
            cyc = 0;
            overlap = 0;
            act_ev.delete();
            act_pulse.delete();
        end else begin
            cyc++;
            if (alu_load_src != 2'b00 || alu_store_to_mem || alu_store_to_stk) begin
                mon_e = '{cyc: 16'(cyc), op: alu_op, a_sel: alu_a_select, b_sel: alu_b_select,
                          out_sel: alu_out_select, a_src: alu_a_source, b_src: alu_b_source,
                          a_alt: alu_a_altern, b_alt: alu_b_altern, load: alu_load_src,
                          st_mem: alu_store_to_mem, st_stk: alu_store_to_stk};
                act_ev.push_back(mon_e);
                if (program_counter_increment) overlap++;
            end
            if (program_counter_increment) act_pulse.push_back({16'(cyc), pc});
            if (alu_load_src == 2'b01 && alu_out_select == 4'd0 && alu_op == ALU_PASS_B)
                pc = alu_b_altern;
            else if (program_counter_increment)
                pc = pc + 16'd1;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    endtask

    // Instruction-level reference: walks the program and lists expected pulses and EXEC strobes.
    task automatic build_model(input logic [15:0] start);
        logic [15:0] a, w, im;
        logic [3:0]  op, rd, rs, f;
        int          t;
        bit          done, tk;
        ev_t         e;
        exp_ev.delete();
        exp_pulse.delete();
        exp_fault = 1'b0;
        exp_pc = start;
        a = start;
        t = 0;
        done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            w  = prog[a[7:0]];
            im = prog[a[7:0] + 8'd1];
            {op, rd, rs, f} = w;
            exp_pulse.push_back({16'(t + 1), a});
            e = '0;
            case (op)
                4'hF: begin
                    exp_pc = a + 16'd1;
                    done = 1;
                end
                4'h1, 4'h2: begin
                    if (op == 4'h2) begin
                        exp_pulse.push_back({16'(t + 3), a + 16'd1});
                        e.cyc = 16'(t + 4); e.b_src = 1'b1; e.b_alt = im;
                        a = a + 16'd2; t += 6;
                    end else begin
                        e.cyc = 16'(t + 2); e.b_sel = rs;
                        a = a + 16'd1; t += 4;
                    end
                    e.op = f; e.a_sel = rd; e.out_sel = rd; e.load = 2'b01;
                    exp_ev.push_back(e);
                    if (errorbit[rd]) begin
                        exp_fault = 1'b1; exp_pc = a; done = 1;
                    end
                end
                4'h3, 4'h6: begin
                    e.cyc = 16'(t + 2); e.op = ALU_PASS_A; e.a_sel = rs; e.out_sel = rd;
                    e.load = (op == 4'h3) ? 2'b10 : 2'b11;
                    exp_ev.push_back(e);
                    a = a + 16'd1; t += 3;
                end
                4'h4, 4'h5: begin
                    e.cyc = 16'(t + 2); e.op = ALU_PASS_A; e.a_sel = rs; e.out_sel = rd;
                    e.st_mem = (op == 4'h4); e.st_stk = (op == 4'h5);
                    exp_ev.push_back(e);
                    a = a + 16'd1; t += 3;
                end
                4'h7: begin
                    exp_pulse.push_back({16'(t + 3), a + 16'd1});
                    case (f)
                        4'd0:    tk = 1;
                        4'd1:    tk = zeroflag[rs];
                        4'd2:    tk = !zeroflag[rs];
                        4'd3:    tk = signflag[rs];
                        4'd4:    tk = !signflag[rs];
                        default: tk = 0;
                    endcase
                    if (tk) begin
                        e.cyc = 16'(t + 4); e.op = ALU_PASS_B; e.b_src = 1'b1; e.b_alt = im; e.load = 2'b01;
                        exp_ev.push_back(e);
                        a = im;
                    end else begin
                        a = a + 16'd2;
                    end
                    t += 5;
                end
                default: begin
                    a = a + 16'd1; t += 3;
                end
            endcase
        end
    endtask

    // Reset, run from start until HALT, and compare the whole trace against the reference.
    task automatic run_program(input string name, input logic [15:0] start);
        int   n;
        logic [15:0] base;
        logic [31:0] ap;
        ev_t  ae;
        reset = 1'b1;
        pc_start = start;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        build_model(start);
        for (int i = 0; i < 500 && halted !== 1'b1; i++) @(posedge clock);
        checks++;
        if (halted !== 1'b1) $display("FAIL %s halt_timeout got=%b want=1", name, halted);
        else passes++;
        repeat (6) @(negedge clock);
        #1;
        checks++;
        if (fault !== exp_fault) $display("FAIL %s fault got=%b want=%b", name, fault, exp_fault);
        else passes++;
        checks++;
        if (pc !== exp_pc) $display("FAIL %s final_pc got=%h want=%h", name, pc, exp_pc);
        else passes++;
        checks++;
        if (overlap !== 0) $display("FAIL %s inc_during_write got=%0d want=0", name, overlap);
        else passes++;
        base = (act_pulse.size() > 0) ? act_pulse[0][31:16] : 16'd0;
        checks++;
        if (act_pulse.size() != exp_pulse.size())
            $display("FAIL %s pulse_count got=%0d want=%0d", name, act_pulse.size(), exp_pulse.size());
        else passes++;
        n = (act_pulse.size() < exp_pulse.size()) ? act_pulse.size() : exp_pulse.size();
        for (int i = 0; i < n; i++) begin
            ap = {act_pulse[i][31:16] - base + 16'd1, act_pulse[i][15:0]};
            checks++;
            if (ap !== exp_pulse[i]) $display("FAIL %s pulse%0d got=%h want=%h", name, i, ap, exp_pulse[i]);
            else passes++;
        end
        checks++;
        if (act_ev.size() != exp_ev.size())
            $display("FAIL %s event_count got=%0d want=%0d", name, act_ev.size(), exp_ev.size());
        else passes++;
        n = (act_ev.size() < exp_ev.size()) ? act_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) begin
            ae = act_ev[i];
            ae.cyc = ae.cyc - base + 16'd1;
            checks++;
            if (ae !== exp_ev[i]) $display("FAIL %s event%0d got=%h want=%h", name, i, ae, exp_ev[i]);
            else passes++;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = 16'h1230;
        errorbit = 16'h0004;
        run_program("reset_pre", 16'h0000);
        reset = 1'b1;
        #1;
        checks++;
        if ({program_counter_increment, alu_op, alu_a_select, alu_b_select, alu_out_select, alu_a_source,
             alu_b_source, alu_a_altern, alu_b_altern, alu_load_src, alu_store_to_mem, alu_store_to_stk} !== '0)
            $display("FAIL reset_outputs got=nonzero want=all_zero");
        else passes++;
        checks++;
        if (halted !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_sticky got=%b%b want=00", halted, fault);
        else passes++;
        errorbit = '0;
    endtask

    task automatic test_reset_mid_store();
        logic seen;
        ev_t  e0;
        clear_prog();
        prog[8'h20] = 16'h4120;
        reset = 1'b1;
        pc_start = 16'h0020;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock);
            #1 seen = alu_store_to_mem;
        end
        checks++;
        if (seen !== 1'b1) $display("FAIL mid_store_seen got=%b want=1", seen);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (alu_store_to_mem !== 1'b0 || alu_load_src !== 2'b00 || halted !== 1'b0)
            $display("FAIL mid_store_abort got=%b%b%b want=0000", alu_store_to_mem, alu_load_src, halted);
        else passes++;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 40 && halted !== 1'b1; i++) @(posedge clock);
        repeat (3) @(negedge clock);
        #1;
        e0 = (act_ev.size() > 0) ? act_ev[0] : '0;
        checks++;
        if (act_ev.size() != 1 || e0.st_mem !== 1'b1 || e0.out_sel !== 4'd1 || e0.a_sel !== 4'd2)
            $display("FAIL mid_store_restart got=%0d/%h want=1 store r1->[r2]", act_ev.size(), e0);
        else passes++;
    endtask

    task automatic test_alur();
        ev_t e0;
        clear_prog();
        prog[8'h10] = 16'h1230;
        run_program("alur", 16'h0010);
        e0 = (act_ev.size() > 0) ? act_ev[0] : '0;
        checks++;
        if (e0.out_sel !== 4'd2 || e0.a_sel !== 4'd2 || e0.b_sel !== 4'd3 || e0.load !== 2'b01 || e0.op !== 4'd0)
            $display("FAIL alur_exec got=%h want=out2 a2 b3 load01", e0);
        else passes++;
        checks++;
        if (act_pulse.size() < 2 || act_pulse[1][31:16] - act_pulse[0][31:16] !== 16'd4 || act_pulse[1][15:0] !== 16'h0011)
            $display("FAIL alur_latency got=%0d pulses want=next fetch at 0011 after 4 cycles", act_pulse.size());
        else passes++;
    endtask

    task automatic test_alui();
        ev_t e0;
        clear_prog();
        prog[8'h18] = 16'h2100;
        prog[8'h19] = 16'h0005;
        run_program("alui", 16'h0018);
        e0 = (act_ev.size() > 0) ? act_ev[0] : '0;
        checks++;
        if (e0.b_src !== 1'b1 || e0.b_alt !== 16'h0005 || e0.out_sel !== 4'd1)
            $display("FAIL alui_exec got=%h want=b_src1 b_alt0005 out1", e0);
        else passes++;
        checks++;
        if (act_pulse.size() !== 3) $display("FAIL alui_pulses got=%0d want=3", act_pulse.size());
        else passes++;
    endtask

    task automatic test_branch();
        ev_t e0;
        clear_prog();
        prog[8'h30] = 16'h7011;
        prog[8'h31] = 16'h0040;
        zeroflag = 16'h0002;
        run_program("br_taken", 16'h0030);
        e0 = (act_ev.size() > 0) ? act_ev[0] : '0;
        checks++;
        if (e0.out_sel !== 4'd0 || e0.b_alt !== 16'h0040 || e0.op !== ALU_PASS_B || e0.load !== 2'b01)
            $display("FAIL br_taken_exec got=%h want=out0 b_alt0040 PASS_B", e0);
        else passes++;
        checks++;
        if (act_pulse.size() < 3 || act_pulse[2][15:0] !== 16'h0040)
            $display("FAIL br_taken_target got=%0d pulses want=fetch at 0040", act_pulse.size());
        else passes++;
        zeroflag = 16'h0000;
        run_program("br_untaken", 16'h0030);
        checks++;
        if (act_pulse.size() < 3 || act_pulse[2][15:0] !== 16'h0032 || act_ev.size() != 0)
            $display("FAIL br_untaken got=%0d pulses %0d events want=fetch at 0032, no events",
                     act_pulse.size(), act_ev.size());
        else passes++;
    endtask

    task automatic test_push();
        ev_t e0;
        clear_prog();
        prog[8'h50] = 16'h5450;
        run_program("push", 16'h0050);
        e0 = (act_ev.size() > 0) ? act_ev[0] : '0;
        checks++;
        if (e0.st_stk !== 1'b1 || e0.st_mem !== 1'b0 || e0.out_sel !== 4'd4 || e0.a_sel !== 4'd5 || e0.op !== ALU_PASS_A)
            $display("FAIL push_exec got=%h want=stk out4 a5 PASS_A", e0);
        else passes++;
    endtask

    task automatic test_fault_and_halt();
        clear_prog();
        prog[8'h60] = 16'h1230;
        prog[8'h61] = 16'h0000;
        errorbit = 16'h0004;
        run_program("alu_fault", 16'h0060);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1 || act_pulse.size() !== 1)
            $display("FAIL alu_fault got=h%b f%b p%0d want=h1 f1 p1", halted, fault, act_pulse.size());
        else passes++;
        errorbit = '0;
        clear_prog();
        run_program("halt", 16'h0070);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0)
            $display("FAIL halt got=h%b f%b want=h1 f0", halted, fault);
        else passes++;
    endtask

    task automatic test_random();
        logic [15:0] iw   [0:8];
        logic [15:0] addr [0:9];
        bit          has_imm [0:8];
        logic [3:0]  op;
        logic [15:0] start;
        for (int it = 0; it < 6; it++) begin
            clear_prog();
            start = 16'(8'h80 + it * 8'h14);
            for (int i = 0; i < 8; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF) op = 4'h0;
                iw[i] = {op, 4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom)};
                if (op == 4'h7) iw[i][3:0] = 4'($urandom_range(0, 7));
                has_imm[i] = (op == 4'h2) || (op == 4'h7);
            end
            iw[8] = 16'hF000;
            has_imm[8] = 0;
            addr[0] = start;
            for (int i = 0; i < 9; i++) addr[i + 1] = addr[i] + (has_imm[i] ? 16'd2 : 16'd1);
            for (int i = 0; i < 9; i++) begin
                prog[addr[i][7:0]] = iw[i];
                if (has_imm[i])
                    prog[addr[i][7:0] + 8'd1] = (iw[i][15:12] == 4'h7) ? addr[$urandom_range(i + 1, 8)] : 16'($urandom);
            end
            zeroflag = 16'($urandom);
            signflag = 16'($urandom);
            errorbit = 16'($urandom & $urandom & $urandom);
            run_program($sformatf("random%0d", it), start);
        end
        zeroflag = '0;
        signflag = '0;
        errorbit = '0;
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_reset_mid_store();
        test_alur();
        test_alui();
        test_branch();
        test_push();
        test_fault_and_halt();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/flow_controller.md
# flow_controller

Multi-cycle instruction sequencer that sits directly upstream of the `datapath` stage. It consumes the fetched instruction word and the per-register flag vectors, and drives every datapath control input: ALU op, operand selects, immediates, write-back source, memory/stack store strobes and PC increment. It runs a fixed FETCH/DECODE/EXECUTE sequence per instruction, and stops on HALT or an ALU error.

## Interface
- No parameters; 4-bit opcode/ALU-op and register-index widths are fixed constants from `flow_pkg`.
- `clock` in 1: single clock; control outputs change on posedge, datapath commits on the following negedge.
- `reset` in 1: asynchronous, active-high; forces state FETCH and all outputs to reset values.
- `instruction` in 16: datapath `current_instruction`, the word at PC, valid one cycle after PC changes.
- `zeroflag`, `signflag`, `errorbit` in 16 each: per-register flag vectors from datapath.
- `program_counter_increment` out 1: one-cycle pulse per instruction word consumed.
- `alu_op` out 4; `alu_a_select`, `alu_b_select`, `alu_out_select` out 4 each.
- `alu_a_source`, `alu_b_source` out 1: 1 selects `alu_a_altern`/`alu_b_altern`.
- `alu_a_altern`, `alu_b_altern` out 16: immediate operands.
- `alu_load_src` out 2: 00 none, 01 ALU result, 10 memory, 11 stack.
- `alu_store_to_mem`, `alu_store_to_stk` out 1: one-cycle store strobes.
- `halted` out 1: sticky high in HALT.
- `fault` out 1: sticky high when halted by ALU error.

## Operation
- Encoding: op=[15:12], rd=[11:8], rs=[7:4], f=[3:0].
  - 0x0 NOP.
  - 0x1 ALUR: rd <= rd f rs.
  - 0x2 ALUI: rd <= rd f imm.
  - 0x3 LD: rd <= mem[rs].
  - 0x4 ST: mem[rs] <= rd.
  - 0x5 PUSH: stk[rs] <= rd.
  - 0x6 POP: rd <= stk[rs].
  - 0x7 BR: if cond f on register rs, PC <= imm.
  - 0xF HALT.
  - Others are treated as NOP.
- imm is always the next word. It is consumed (PC incremented) even when a branch is not taken.
- BR cond f:
  - 0 always.
  - 1 zeroflag[rs].
  - 2 !zeroflag[rs].
  - 3 signflag[rs].
  - 4 !signflag[rs].
  - Others never.
- States and transitions:
  - FETCH: wait one cycle for `instruction` to settle; → DECODE.
  - DECODE: latch IR, pulse increment.
    - ALUI/BR → IMM.
    - HALT → HALT.
    - Otherwise → EXEC.
  - IMM: wait one cycle for the immediate word → IMMLATCH.
  - IMMLATCH: latch IMM, pulse increment; → EXEC.
  - EXEC: drive the op for exactly one cycle.
    - ALUR/ALUI: a_select=rd, b=rs or imm, load_src=01, out_select=rd.
    - LD/POP: a_select=rs, alu_op=PASS_A, load_src=10 or 11.
    - ST/PUSH: address=rs via PASS_A, out_select=rd, store strobe.
    - Taken BR: b_altern=imm, alu_op=PASS_B, out_select=0 (PC), load_src=01, increment=0.
    - Untaken BR/NOP: nothing asserted.
    - ALU ops → CHECK; all others → FETCH.
  - CHECK: read `errorbit[rd]`; 1 → HALT with fault=1, else → FETCH.
  - HALT: absorbing; only `reset` exits.
- Increment is never asserted in the same cycle as a write to register 0. BR writes an absolute target.
- When rd=0, an ALU op writes the PC; this is legal and behaves as a jump.

## Timing
- Reset values: state FETCH, all outputs 0, `alu_load_src`=00, IR/IMM=0.
- Control outputs are registered, so they are stable a half-cycle before the datapath negedge.
- Store and load_src strobes are high for exactly one cycle. The default is deasserted in every non-EXEC state.
- Latency per instruction:
  - NOP/LD/ST/PUSH/POP: 3 cycles.
  - ALUR: 4 cycles.
  - ALUI: 6 cycles.
  - BR: 5 cycles.
- Reset asserted mid-instruction aborts immediately and drops all strobes that cycle. No partial store is issued after reset rises.
- PC wrap 0xFFFF→0x0000 is the natural 16-bit roll; the controller does not detect it.

## Structure
- `flow_pkg`: opcode constants, BR condition codes, ALU op constants (PASS_A, PASS_B, matching the ALU table), `alu_load_src` encodings, state enum.
- One sub-module, `branch_condition`: combinational; inputs f, rs, zeroflag, signflag; output taken.

## Test plan
- Reset mid-EXEC of ST: `reset` rises → `alu_store_to_mem`=0 that cycle, state FETCH, `halted`=0.
- ALUR 0x1230 (r2 <= r2 ADD r3): exactly one `alu_load_src`=01 cycle with out_select=2, a=2, b=3; PC advances by 1; 4 cycles total.
- ALUI 0x2100, imm 0x0005: two increment pulses; EXEC drives b_source=1, b_altern=0x0005.
- BR 0x7011, imm 0x0040, zeroflag[1]=1: out_select=0, b_altern=0x0040, increment=0 in EXEC; next fetch is at 0x0040. With zeroflag[1]=0, PC=start+2.
- PUSH 0x5450: one `alu_store_to_stk` pulse with out_select=4, a_select=5, PASS_A.
- ALUR with `errorbit[rd]`=1 after EXEC → `halted`=1, `fault`=1, no further increments. HALT 0xF000 → `halted`=1, `fault`=0.
